message_writer: RTL
===================

Name: message_writer

Overview:
- Writer side of the on-screen text path: fills a 16-slot character buffer that the glyph renderer reads each frame.
- On a game-state trigger, the block first blanks all 16 slots.
- It then writes the selected banner one letter code per slot, with a programmable delay between letters (typewriter reveal).
- It sits between the game-state logic and the text-buffer RAM write port.

Parameters:
- CHAR_DELAY, 2500000, clocks between successive letter writes (≥1; 1 = back-to-back).
- SLOTS, 16, number of text-buffer slots; fixes wr_addr width at 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- get_ready  input  1  level; rising edge selects "GET READY"
- times_up  input  1  level; rising edge selects "TIME IS UP"
- leaderboard  input  1  level; rising edge selects "HOUSE CUP"
- wr_en  output  1  text-buffer write strobe, one write per asserted cycle
- wr_addr  output  4  slot index
- wr_data  output  5  letter code
- busy  output  1  high while clearing or typing
- done  output  1  one-cycle pulse after the last letter write

Behaviour:
- Letter code: A=0 … Z=25, space=26, blank=31.
- Message tables (internal constants):
  - GET READY = 6,4,19,26,17,4,0,3,24 (length 9)
  - TIME IS UP = 19,8,12,4,26,8,18,26,20,15 (length 10)
  - HOUSE CUP = 7,14,20,18,4,26,2,20,15 (length 9)
- Reset (async, resetn=0):
  - state IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - Edge-history registers=0, so an input already high at reset release is detected as a rising edge on the first clock.
- Edge detect: trigger = input high while its registered previous value is low.
  - Priority for simultaneous edges: leaderboard > times_up > get_ready.
  - Falling edges are ignored; the buffer keeps its last content.
- States:
  - IDLE: on trigger, latch the message select and go to CLEAR.
  - CLEAR: wr_en=1, wr_data=31, wr_addr counts 0..15, one slot per cycle (16 cycles), then TYPE.
  - TYPE: wr_en=1, wr_addr=i, wr_data=msg[i] (one cycle).
    - If i is the last index, go to DONE.
    - Else if CHAR_DELAY=1, stay in TYPE with i+1.
    - Else go to WAIT.
  - WAIT: wr_en=0; hold for CHAR_DELAY-1 cycles, then TYPE with i+1.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing: let cycle 0 be the clock edge that detects the trigger.
  - Clear writes occur in cycles 1–16.
  - Letter i is written in cycle 17 + i·CHAR_DELAY.
  - done pulses one cycle after the last letter write.
  - busy=1 from cycle 1 through the last letter cycle inclusive.
- wr_addr and wr_data are don't-care when wr_en=0 but must hold their last value (no toggling).
- Trigger while busy: abort immediately.
  - The next cycle restarts CLEAR at slot 0 with the new message.
  - No done pulse is issued for the aborted message.
- Trigger in the DONE cycle: done still pulses; the next cycle enters CLEAR.
- Slots from the message length up to 15 remain blank (31) from the clear pass.
- Delay counter width is $clog2(CHAR_DELAY)+1; it reloads on every TYPE and on abort.

Test Plan:
1. Reset, then CHAR_DELAY=4, then a get_ready rising edge at cycle 0.
   - Expect wr_en with data 31 at addrs 0..15 in cycles 1–16.
   - Expect letters 6,4,19,26,17,4,0,3,24 at addrs 0..8 in cycles 17,21,…,49.
   - Expect done=1 only in cycle 50, and busy low from cycle 50.
2. CHAR_DELAY=1, times_up edge.
   - Expect 10 consecutive letter writes in cycles 17–26: 19,8,12,4,26,8,18,26,20,15.
   - Expect done in cycle 27.
   - Expect exactly 26 wr_en cycles in total.
3. get_ready and leaderboard rise in the same cycle.
   - Expect the HOUSE CUP sequence 7,14,20,18,4,26,2,20,15; no GET READY codes.
4. leaderboard edge during the typing of GET READY (after letter 3).
   - Next cycle: CLEAR restarts at addr 0.
   - HOUSE CUP then types fully.
   - Exactly one done pulse in the whole run.
5. Assert resetn=0 asynchronously in the middle of a WAIT.
   - All outputs go 0 before the next clock edge.
   - get_ready held high through reset release gives a new sequence starting at cycle 1 after release.
6. Input held high for the whole run after done.
   - No re-trigger, wr_en stays 0.
   - A falling then rising edge produces a full new sequence.

Source files
------------

// File: rtl/message_writer.sv
// rtl/message_writer.sv - text-buffer writer: clears 16 slots then types a banner with per-letter delay
//
// Purpose:
//   Rising edges on get_ready / times_up / leaderboard select a banner.
//   The block first writes blank (31) into every slot, then writes the banner
//   letters one per slot. CHAR_DELAY clocks separate successive letters.
//   A new trigger at any time aborts the current work and restarts the clear.
//
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   get_ready    in   level; rising edge selects "GET READY"
//   times_up     in   level; rising edge selects "TIME IS UP"
//   leaderboard  in   level; rising edge selects "HOUSE CUP" (highest priority)
//   wr_en        out  text-buffer write strobe
//   wr_addr[3:0] out  slot index
//   wr_data[4:0] out  letter code (A=0..Z=25, space=26, blank=31)
//   busy         out  high while clearing or typing
//   done         out  one-cycle pulse after the last letter write

module message_writer #(
    parameter int CHAR_DELAY = 2500000,
    parameter int SLOTS      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       get_ready,
    input  logic       times_up,
    input  logic       leaderboard,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [4:0] wr_data,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CHAR_DELAY) + 1;
    // WAIT lasts CHAR_DELAY-1 cycles; the counter runs from RELOAD down to 0.
    localparam int RELOAD = (CHAR_DELAY >= 2) ? (CHAR_DELAY - 2) : 0;
    localparam logic [CW-1:0] RELOAD_V  = CW'(RELOAD);
    localparam logic [3:0]    LAST_SLOT = 4'(SLOTS - 1);
    localparam logic [4:0]    BLANK     = 5'd31;

    localparam logic [1:0] SEL_GR = 2'd0;
    localparam logic [1:0] SEL_TU = 2'd1;
    localparam logic [1:0] SEL_HC = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_TYPE  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] msg_len(input logic [1:0] sel);
        case (sel)
            SEL_TU:  return 4'd10;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [4:0] msg_code(input logic [1:0] sel, input logic [3:0] idx);
        logic [4:0] c;
        c = BLANK;
        case (sel)
            SEL_GR: begin
                case (idx)
                    4'd0: c = 5'd6;
                    4'd1: c = 5'd4;
                    4'd2: c = 5'd19;
                    4'd3: c = 5'd26;
                    4'd4: c = 5'd17;
                    4'd5: c = 5'd4;
                    4'd6: c = 5'd0;
                    4'd7: c = 5'd3;
                    4'd8: c = 5'd24;
                    default: c = BLANK;
                endcase
            end
            SEL_TU: begin
                case (idx)
                    4'd0: c = 5'd19;
                    4'd1: c = 5'd8;
                    4'd2: c = 5'd12;
                    4'd3: c = 5'd4;
                    4'd4: c = 5'd26;
                    4'd5: c = 5'd8;
                    4'd6: c = 5'd18;
                    4'd7: c = 5'd26;
                    4'd8: c = 5'd20;
                    4'd9: c = 5'd15;
                    default: c = BLANK;
                endcase
            end
            SEL_HC: begin
                case (idx)
                    4'd0: c = 5'd7;
                    4'd1: c = 5'd14;
                    4'd2: c = 5'd20;
                    4'd3: c = 5'd18;
                    4'd4: c = 5'd4;
                    4'd5: c = 5'd26;
                    4'd6: c = 5'd2;
                    4'd7: c = 5'd20;
                    4'd8: c = 5'd15;
                    default: c = BLANK;
                endcase
            end
            default: c = BLANK;
        endcase
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   dly_q, dly_d;
    logic [1:0]      sel_q, sel_d;
    logic            gr_prev_q, tu_prev_q, lb_prev_q;
    logic            wr_en_q, wr_en_d;
    logic [3:0]      wr_addr_q, wr_addr_d;
    logic [4:0]      wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            trig_gr, trig_tu, trig_lb, any_trig;
    logic [1:0]      trig_sel;

    assign trig_gr  = get_ready   & ~gr_prev_q;
    assign trig_tu  = times_up    & ~tu_prev_q;
    assign trig_lb  = leaderboard & ~lb_prev_q;
    assign any_trig = trig_gr | trig_tu | trig_lb;
    assign trig_sel = trig_lb ? SEL_HC : (trig_tu ? SEL_TU : SEL_GR);

    // Outputs are registered from the current state, so each write appears
    // the cycle after the state that produces it.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dly_d     = dly_q;
        sel_d     = sel_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
            end
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = BLANK;
                busy_d    = 1'b1;
                if (idx_q == LAST_SLOT) begin
                    state_d = S_TYPE;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_TYPE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = msg_code(sel_q, idx_q);
                busy_d    = 1'b1;
                if (idx_q == msg_len(sel_q) - 4'd1) begin
                    state_d = S_DONE;
                end else if (CHAR_DELAY == 1) begin
                    idx_d = idx_q + 4'd1;
                end else begin
                    state_d = S_WAIT;
                    idx_d   = idx_q + 4'd1;
                    dly_d   = RELOAD_V;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (dly_q == '0) begin
                    state_d = S_TYPE;
                end else begin
                    dly_d = dly_q - CW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new trigger overrides the next state from anywhere; the output of
        // the current cycle (including a DONE pulse) still goes out.
        if (any_trig) begin
            state_d = S_CLEAR;
            idx_d   = 4'd0;
            sel_d   = trig_sel;
            dly_d   = RELOAD_V;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            dly_q     <= '0;
            sel_q     <= SEL_GR;
            gr_prev_q <= 1'b0;
            tu_prev_q <= 1'b0;
            lb_prev_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dly_q     <= dly_d;
            sel_q     <= sel_d;
            gr_prev_q <= get_ready;
            tu_prev_q <= times_up;
            lb_prev_q <= leaderboard;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
